dso_capture_ctrl: RTL and testbench

Sequences A2D sample capture for the three scope channels on `adc_clk`. It takes the 8-bit `ch1_data`/`ch2_data`/`ch3_data` words and the `trig1`/`trig2` comparator outputs from the analog front end, decimates them, and writes them into a circular sample RAM. It guarantees a configurable pre-trigger fill, detects the selected trigger edge, captures a programmed number of post-trigger samples, then holds the buffer until the host acknowledges.

---
 rtl/dso_pkg.sv | 19 +
 rtl/dso_trig_detect.sv | 35 +++
 rtl/dso_capture_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dso_capture_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dso_pkg.sv
// Shared types and constants for the scope capture controller.
package dso_pkg;

  localparam int unsigned DSO_ADDR_W = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } dso_state_e;

  localparam logic [1:0] TRIG_SRC_T1     = 2'd0;
  localparam logic [1:0] TRIG_SRC_T2     = 2'd1;
  localparam logic [1:0] TRIG_SRC_MANUAL = 2'd2;
  localparam logic [1:0] TRIG_SRC_T1_ALT = 2'd3;

endpackage

// File: rtl/dso_trig_detect.sv
// Trigger source mux, previous-sample register and edge compare.
module dso_trig_detect
  import dso_pkg::*;
(
  input  logic       adc_clk,
  input  logic       rst_n,
  input  logic       trig1,
  input  logic       trig2,
  input  logic [1:0] trig_src,
  input  logic       trig_edge,
  input  logic       smp_en,
  input  logic       eval_en,
  output logic       fire
);

  logic sel;
  logic edge_hit;
  logic trig_prev_q;

  always_comb begin
    sel = trig1;
    if (trig_src == TRIG_SRC_T2) sel = trig2;
    edge_hit = trig_edge ? (sel & ~trig_prev_q) : (~sel & trig_prev_q);
    fire     = smp_en & eval_en & ((trig_src == TRIG_SRC_MANUAL) | edge_hit);
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev_q <= 1'b0;
    end else if (smp_en) begin
      trig_prev_q <= sel;
    end
  end

endmodule

// File: rtl/dso_capture_ctrl.sv
// Decimating circular-buffer capture sequencer: pre-fill, trigger, post-fill, hold.
module dso_capture_ctrl
  import dso_pkg::*;
#(
  parameter int unsigned ADDR_W = DSO_ADDR_W
) (
  input  logic              adc_clk,
  input  logic              rst_n,
  input  logic [7:0]        ch1_data,
  input  logic [7:0]        ch2_data,
  input  logic [7:0]        ch3_data,
  input  logic              trig1,
  input  logic              trig2,
  input  logic              arm,
  input  logic              done_clr,
  input  logic [1:0]        trig_src,
  input  logic              trig_edge,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [3:0]        decimator,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [23:0]       wdata,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              capture_done
);

  dso_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [15:0]       dec_cnt_q, dec_cnt_d;
  logic [15:0]       dec_mask;
  logic [ADDR_W-1:0] pre_rem_q, pre_rem_d;
  logic [ADDR_W-1:0] post_rem_q, post_rem_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [1:0]        src_q, src_d;
  logic              edge_q, edge_d;
  logic [ADDR_W-1:0] tpos_q, tpos_d;
  logic [3:0]        dec_q, dec_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [23:0]       wdata_q;
  logic              armed_q, done_q;
  logic              active;
  logic              smp_en;
  logic              fire;

  assign active   = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
  assign smp_en   = active && (dec_cnt_q == '0);
  assign dec_mask = 16'((17'd1 << dec_q) - 17'd1);

  dso_trig_detect u_trig (
    .adc_clk   (adc_clk),
    .rst_n     (rst_n),
    .trig1     (trig1),
    .trig2     (trig2),
    .trig_src  (src_q),
    .trig_edge (edge_q),
    .smp_en    (smp_en),
    .eval_en   (state_q == ARMED),
    .fire      (fire)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    dec_cnt_d   = dec_cnt_q;
    pre_rem_d   = pre_rem_q;
    post_rem_d  = post_rem_q;
    trig_addr_d = trig_addr_q;
    src_d       = src_q;
    edge_d      = edge_q;
    tpos_d      = tpos_q;
    dec_d       = dec_q;

    if (active) begin
      dec_cnt_d = (dec_cnt_q + 16'd1) & dec_mask;
      if (smp_en) wptr_d = wptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (arm) begin
          src_d     = trig_src;
          edge_d    = trig_edge;
          tpos_d    = trig_pos;
          dec_d     = decimator;
          wptr_d    = '0;
          dec_cnt_d = '0;
          // D-1-trig_pos in ADDR_W bits
          pre_rem_d = '1 - trig_pos;
          state_d   = (pre_rem_d == '0) ? ARMED : PRE;
        end
      end
      PRE: begin
        if (smp_en) begin
          pre_rem_d = pre_rem_q - 1'b1;
          if (pre_rem_q == ADDR_W'(1)) state_d = ARMED;
        end
      end
      ARMED: begin
        if (fire) begin
          trig_addr_d = wptr_q;
          post_rem_d  = tpos_q;
          state_d     = (tpos_q == '0) ? DONE : POST;
        end
      end
      POST: begin
        if (smp_en) begin
          post_rem_d = post_rem_q - 1'b1;
          if (post_rem_q == ADDR_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (done_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      dec_cnt_q   <= '0;
      pre_rem_q   <= '0;
      post_rem_q  <= '0;
      trig_addr_q <= '0;
      src_q       <= '0;
      edge_q      <= 1'b0;
      tpos_q      <= '0;
      dec_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      dec_cnt_q   <= dec_cnt_d;
      pre_rem_q   <= pre_rem_d;
      post_rem_q  <= post_rem_d;
      trig_addr_q <= trig_addr_d;
      src_q       <= src_d;
      edge_q      <= edge_d;
      tpos_q      <= tpos_d;
      dec_q       <= dec_d;
      we_q        <= smp_en;
      if (smp_en) begin
        waddr_q <= wptr_q;
        wdata_q <= {ch3_data, ch2_data, ch1_data};
      end
      armed_q     <= (state_d == ARMED);
      done_q      <= (state_d == DONE);
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign trig_addr    = trig_addr_q;
  assign armed        = armed_q;
  assign capture_done = done_q;

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed/randomized bench for dso_capture_ctrl against a sample-index reference model.
module tb_dso_capture_ctrl;

  localparam int DEPTH = 512;
  localparam int MAXC  = 8192;
  localparam int MAXS  = 2048;

  logic        adc_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [7:0]  ch1_data = '0, ch2_data = '0, ch3_data = '0;
  logic        trig1 = 1'b0, trig2 = 1'b0, arm = 1'b0, done_clr = 1'b0;
  logic [1:0]  trig_src = '0;
  logic        trig_edge = 1'b0;
  logic [8:0]  trig_pos = '0;
  logic [3:0]  decimator = '0;
  logic        we;
  logic [8:0]  waddr;
  logic [23:0] wdata;
  logic [8:0]  trig_addr;
  logic        armed, capture_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          e;
    int          addr;
    logic [23:0] data;
  } wr_t;

  wr_t         got[$];
  logic [23:0] chd[MAXC];
  bit          s1[MAXS];
  bit          s2[MAXS];

  dso_capture_ctrl #(.ADDR_W(9)) dut (
    .adc_clk      (adc_clk),
    .rst_n        (rst_n),
    .ch1_data     (ch1_data),
    .ch2_data     (ch2_data),
    .ch3_data     (ch3_data),
    .trig1        (trig1),
    .trig2        (trig2),
    .arm          (arm),
    .done_clr     (done_clr),
    .trig_src     (trig_src),
    .trig_edge    (trig_edge),
    .trig_pos     (trig_pos),
    .decimator    (decimator),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .trig_addr    (trig_addr),
    .armed        (armed),
    .capture_done (capture_done)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random_trig();
    s1[0] = 1'($urandom);
    s2[0] = 1'($urandom);
    for (int j = 1; j < MAXS; j++) begin
      s1[j] = ($urandom_range(0, 3) == 0) ? ~s1[j-1] : s1[j-1];
      s2[j] = ($urandom_range(0, 3) == 0) ? ~s2[j-1] : s2[j-1];
    end
  endtask

  // Model: sample j lands at edge 1+j*2^d, address j mod D. The trigger is the
  // first sample at or after index D-1-tpos that meets the source/edge rule.
  task automatic run_capture(input string tag, input int src, input int edg,
                             input int tpos, input int d, input int abort_at,
                             output int k_out);
    int pre, k, total, done_e, armed_cnt, f0, exp_e;
    bit cur, prv;
    pre = DEPTH - 1 - tpos;
    k = MAXS;
    for (int j = pre; j < MAXS; j++) begin
      cur = (src == 1) ? s2[j] : s1[j];
      prv = (src == 1) ? s2[j-1] : s1[j-1];
      if (src == 2 || (edg != 0 ? (cur && !prv) : (!cur && prv))) begin
        k = j;
        break;
      end
    end
    k_out = k;
    total = k + 1 + tpos;
    got.delete();

    trig_src = 2'(src); trig_edge = 1'(edg); trig_pos = 9'(tpos); decimator = 4'(d);
    arm = 1'b1;
    @(posedge adc_clk); #1;
    arm = 1'b0;
    done_e = -1;
    armed_cnt = 0;
    for (int e = 1; e < MAXC; e++) begin
      int j;
      j = (e - 1) >> d;
      chd[e] = 24'($urandom);
      {ch3_data, ch2_data, ch1_data} = chd[e];
      if (((e - 1) % (1 << d)) == 0 && j < MAXS) begin
        trig1 = s1[j];
        trig2 = s2[j];
      end else begin
        trig1 = 1'($urandom);
        trig2 = 1'($urandom);
      end
      trig_src  = 2'($urandom);
      trig_edge = 1'($urandom);
      trig_pos  = 9'($urandom);
      decimator = 4'($urandom);
      arm       = ($urandom_range(0, 15) == 0);
      done_clr  = ($urandom_range(0, 15) == 0);
      @(posedge adc_clk); #1;
      if (we) got.push_back('{e, int'(waddr), wdata});
      if (armed) armed_cnt++;
      if (e == abort_at) begin
        arm = 1'b0; done_clr = 1'b0;
        chk({tag, "_in_post_done"}, {63'd0, capture_done}, 64'd0);
        chk({tag, "_in_post_armed"}, {63'd0, armed}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_we"}, {63'd0, we}, 64'd0);
        chk({tag, "_rst_waddr"}, {55'd0, waddr}, 64'd0);
        chk({tag, "_rst_wdata"}, {40'd0, wdata}, 64'd0);
        chk({tag, "_rst_trig_addr"}, {55'd0, trig_addr}, 64'd0);
        chk({tag, "_rst_armed"}, {63'd0, armed}, 64'd0);
        chk({tag, "_rst_done"}, {63'd0, capture_done}, 64'd0);
        @(posedge adc_clk); @(posedge adc_clk); #1;
        rst_n = 1'b1;
        f0 = 0;
        repeat (8) begin
          @(posedge adc_clk); #1;
          f0 += int'(we) + int'(armed) + int'(capture_done);
        end
        chk({tag, "_idle_after_rst"}, 64'(f0), 64'd0);
        return;
      end
      if (capture_done) begin
        done_e = e;
        break;
      end
    end
    arm = 1'b0;
    done_clr = 1'b0;

    chk({tag, "_reached_done"}, {63'd0, done_e >= 0}, 64'd1);
    chk({tag, "_num_writes"}, 64'(got.size()), 64'(total));
    f0 = failures;
    for (int i = 0; i < got.size() && i < total && failures == f0; i++) begin
      exp_e = 1 + (i << d);
      chk({tag, "_write_edge"}, 64'(got[i].e), 64'(exp_e));
      chk({tag, "_waddr"}, 64'(got[i].addr), 64'(i % DEPTH));
      if (exp_e < MAXC) chk({tag, "_wdata"}, {40'd0, got[i].data}, {40'd0, chd[exp_e]});
    end
    chk({tag, "_done_edge"}, 64'(done_e), 64'(1 + ((total - 1) << d)));
    chk({tag, "_trig_addr"}, {55'd0, trig_addr}, 64'(k % DEPTH));
    chk({tag, "_armed_cycles"}, 64'(armed_cnt), 64'((k - pre + 1) << d));
  endtask

  task automatic hold_and_clear(input string tag);
    int n;
    n = 0;
    repeat (3) begin
      @(posedge adc_clk); #1;
      n += int'(we) + int'(!capture_done);
    end
    chk({tag, "_done_hold"}, 64'(n), 64'd0);
    done_clr = 1'b1;
    @(posedge adc_clk); #1;
    done_clr = 1'b0;
    chk({tag, "_done_clr"}, {63'd0, capture_done}, 64'd0);
  endtask

  initial begin
    int k;
    int n;

    repeat (3) @(posedge adc_clk);
    #1;
    chk("reset_we", {63'd0, we}, 64'd0);
    chk("reset_waddr", {55'd0, waddr}, 64'd0);
    chk("reset_wdata", {40'd0, wdata}, 64'd0);
    chk("reset_trig_addr", {55'd0, trig_addr}, 64'd0);
    chk("reset_flags", {62'd0, armed, capture_done}, 64'd0);
    rst_n = 1'b1;
    @(posedge adc_clk); #1;

    // trig1 high through PRE, low at ARMED start, rises at ARMED write 20
    fill_random_trig();
    for (int j = 0; j < MAXS; j++) s1[j] = (j < 411) || (j >= 431);
    run_capture("prepost", 0, 1, 100, 0, 0, k);
    chk("prepost_k", 64'(k), 64'd431);
    chk("prepost_trig_addr_abs", {55'd0, trig_addr}, 64'd431);
    chk("prepost_last_addr", 64'(got[$].addr), 64'd19);
    chk("prepost_pre_last_addr", 64'(got[410].addr), 64'd410);

    arm = 1'b1;
    @(posedge adc_clk); #1;
    arm = 1'b0;
    chk("arm_in_done_stays", {63'd0, capture_done}, 64'd1);
    chk("arm_in_done_no_we", {63'd0, we}, 64'd0);
    arm = 1'b1; done_clr = 1'b1;
    @(posedge adc_clk); #1;
    arm = 1'b0; done_clr = 1'b0;
    chk("arm_clr_done_low", {63'd0, capture_done}, 64'd0);
    n = 0;
    repeat (20) begin
      @(posedge adc_clk); #1;
      n += int'(we) + int'(armed) + int'(capture_done);
    end
    chk("arm_clr_no_capture", 64'(n), 64'd0);

    fill_random_trig();
    run_capture("rst_mid_post", 2, 1, 200, 0, 400, k);

    fill_random_trig();
    run_capture("decim4", 0, 1, 300, 2, 0, k);
    hold_and_clear("decim4");

    fill_random_trig();
    run_capture("manual", 2, 0, 0, 0, 0, k);
    chk("manual_total", 64'(got.size()), 64'd512);
    chk("manual_trig_addr_abs", {55'd0, trig_addr}, 64'd511);
    hold_and_clear("manual");

    fill_random_trig();
    for (int j = 0; j < MAXS; j++) s2[j] = (j >= 470) && (j < 480);
    run_capture("falling", 1, 0, 50, 1, 0, k);
    chk("falling_k", 64'(k), 64'd480);
    hold_and_clear("falling");

    for (int r = 0; r < 3; r++) begin
      fill_random_trig();
      run_capture("random", $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 510), $urandom_range(0, 3), 0, k);
      hold_and_clear("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
